// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states and the datapath step mode.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_e;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_e;

  // Divides sit in the upper half of the op space; even codes are signed.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a
// restoring divide step on the 2*DATA_W accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   operand,
  input  step_mode_e          mode,
  output logic [2*DATA_W-1:0] acc_next
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   top;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // Multiply keeps the multiplier in the low half and shifts it out LSB first;
  // divide keeps the dividend there and shifts quotient bits in at the bottom.
  always_comb begin
    sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
    top      = acc[2*DATA_W-1:DATA_W-1];
    fits     = (top >= {1'b0, operand});
    diff     = top[DATA_W-1:0] - operand;
    acc_next = acc;
    if (mode == STEP_MUL) begin
      acc_next = {sum, acc[DATA_W-1:1]};
    end else if (fits) begin
      acc_next = {diff, acc[DATA_W-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; DATA_W+3 cycle
// latency, abortable by kill_i, with MTHI/MTLO writes while idle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              kill_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              dbz_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  state_e              state;
  state_e              state_next;
  logic                accept;
  logic                finish;

  logic [1:0]          op_q;
  logic [DATA_W-1:0]   rs_q;
  logic [DATA_W-1:0]   rt_q;
  logic [DATA_W-1:0]   operand_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_lo_q;
  logic                neg_hi_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                done_q;
  logic                dbz_q;

  logic                is_div;
  logic                is_signed;
  logic                rs_neg;
  logic                rt_neg;
  logic [DATA_W-1:0]   rs_abs;
  logic [DATA_W-1:0]   rt_abs;
  step_mode_e          mode;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   quotient;
  logic [DATA_W-1:0]   remainder;
  logic [DATA_W-1:0]   hi_res;
  logic [DATA_W-1:0]   lo_res;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A kill anywhere past IDLE abandons the operation, including FIX's write.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = PREP;
        end
      end
      PREP: state_next = RUN;
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (kill_i && state != IDLE) begin
      finish     = 1'b0;
      state_next = IDLE;
    end
  end

  always_comb begin
    is_div    = op_is_div(op_q);
    is_signed = op_is_signed(op_q);
    rs_neg    = is_signed & rs_q[DATA_W-1];
    rt_neg    = is_signed & rt_q[DATA_W-1];
    rs_abs    = rs_neg ? -rs_q : rs_q;
    rt_abs    = rt_neg ? -rt_q : rt_q;
    mode      = is_div ? STEP_DIV : STEP_MUL;
  end

  muldiv_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .acc     (acc_q),
    .operand (operand_q),
    .mode    (mode),
    .acc_next(acc_next)
  );

  // Sign correction; divide by zero bypasses it and returns the raw dividend.
  always_comb begin
    product   = neg_lo_q ? -acc_q : acc_q;
    quotient  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    remainder = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    hi_res    = product[2*DATA_W-1:DATA_W];
    lo_res    = product[DATA_W-1:0];
    if (is_div) begin
      if (rt_q == '0) begin
        hi_res = rs_q;
        lo_res = '1;
      end else begin
        hi_res = remainder;
        lo_res = quotient;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op_i;
        rs_q <= rs_i;
        rt_q <= rt_i;
      end
      if (state == PREP) begin
        neg_lo_q  <= rs_neg ^ rt_neg;
        neg_hi_q  <= rs_neg;
        operand_q <= is_div ? rt_abs : rs_abs;
        acc_q     <= {{DATA_W{1'b0}}, (is_div ? rs_abs : rt_abs)};
        cnt_q     <= CNT_W'(DATA_W);
      end
      if (state == RUN) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // HI/LO take results at FIX, or MTHI/MTLO data only while idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        dbz_q <= 1'b0;
      end
      if (finish) begin
        hi_q  <= hi_res;
        lo_q  <= lo_res;
        dbz_q <= is_div && (rt_q == '0);
      end else if (state == IDLE) begin
        if (hi_we_i) begin
          hi_q <= wdata_i;
        end
        if (lo_we_i) begin
          lo_q <= wdata_i;
        end
      end
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = done_q;
  assign dbz_o  = dbz_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS core.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles. The core stalls on busy_o and reads hi_o/lo_o for MFHI/MFLO.
- Extends the single-cycle datapath with the first multi-cycle execution resource.
- Width is generic, so the same block serves the 32-bit core and narrower test builds.

Parameters:
- DATA_W, 32: operand and HI/LO width. Legal values are 4 to 64.
- CNT_W, $clog2(DATA_W+1): iteration counter width. Derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request a new operation; sampled only when busy_o=0
- op_i  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_i  in  DATA_W  multiplicand / dividend
- rt_i  in  DATA_W  multiplier / divisor
- kill_i  in  1  abort the operation in flight (pipeline flush)
- hi_we_i  in  1  MTHI write enable
- lo_we_i  in  1  MTLO write enable
- wdata_i  in  DATA_W  MTHI/MTLO data
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse; HI/LO hold the new result
- dbz_o  out  1  sticky divide-by-zero flag for the last operation
- hi_o  out  DATA_W  HI register
- lo_o  out  DATA_W  LO register

Behaviour:
- Reset (asynchronous, active-high) forces hi_o=0, lo_o=0, busy_o=0, done_o=0, dbz_o=0, and the FSM to IDLE. Reset mid-operation discards the operation, with no done pulse.
- FSM states: IDLE -> PREP -> RUN -> FIX -> IDLE.
- IDLE: on start_i=1, latch op_i, rs_i and rt_i, and go to PREP. busy_o is registered high from the next cycle.
- PREP (1 cycle):
  - Signed ops take absolute values of the operands and record the result signs. The quotient sign is the XOR of the operand signs; the remainder sign is the dividend sign.
  - Clear the 2*DATA_W accumulator and load the counter with DATA_W.
- RUN (exactly DATA_W cycles):
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring step per cycle.
  - The counter decrements each cycle; go to FIX when the counter reaches 0.
- FIX (1 cycle): apply sign correction and write HI/LO at the end of the cycle.
  - Multiply: HI/LO = upper/lower halves of the 2*DATA_W product.
  - Divide: LO = quotient, HI = remainder.
- Timing: start sampled in cycle T. busy_o=1 in cycles T+1 through T+DATA_W+2. done_o=1 only in cycle T+DATA_W+3, with busy_o=0 in that cycle. Total latency is DATA_W+3.
- A new start_i is accepted in the done_o cycle, so back-to-back issue works.
- start_i while busy_o=1 is ignored; no queueing.
- Divide by zero (rt=0):
  - Full latency still applies.
  - Result is LO = all ones and HI = dividend (original signed value for DIV).
  - dbz_o is set at FIX and stays set until the next accepted start.
  - Multiplies clear dbz_o on start.
- Signed overflow (DIV of most-negative by -1): LO = most-negative, HI = 0, dbz_o=0.
- Arithmetic is modulo 2^DATA_W per register. MULTU and DIVU treat operands as unsigned.
- kill_i:
  - In PREP, RUN or FIX: go to IDLE next cycle with HI/LO unchanged, no done_o, and busy_o=0 next cycle.
  - kill_i overrides FIX's write in the same cycle.
  - kill_i in IDLE has no effect, and a simultaneous start is still accepted.
- MTHI/MTLO writes:
  - hi_we_i/lo_we_i write wdata_i at the clock edge only when busy_o=0.
  - They are ignored while busy_o=1.
  - A write in the same cycle as an accepted start is applied; the later FIX overwrites it.
- hi_o and lo_o are direct register outputs; there is no combinational path from inputs.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the FSM state enum (IDLE, PREP, RUN, FIX).
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator.
  - Instantiated once inside the FSM/register top.

Test Plan (DATA_W=32):
- MULT rs=0xFFFFFFFD (-3), rt=7, start at T -> done_o exactly at T+35; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy_o high T+1..T+34.
- DIVU rs=100, rt=7 -> LO=14, HI=2, dbz_o=0. Then DIV rs=0xFFFFFFF9 (-7), rt=2 issued in the done cycle -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0. Then DIVU rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5, dbz_o=1 until the next start.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with kill_i at T+10 -> busy_o=0 at T+11, no done_o, HI/LO keep their prior values. A start_i pulse at T+5 during the operation is ignored.
- hi_we_i with wdata=0x1234 while idle -> hi_o=0x1234 next cycle. The same write while busy is ignored. rst_i asserted mid-RUN (asynchronous, between clock edges) -> all outputs 0 immediately.
